// File: rtl/ram.sv
// Simple dual-port RAM (one write, one read port) with registered, read-first output.
// Read data appears 1 cycle after a read request and holds otherwise; no backpressure.
module ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_write_addr,
    input  logic                  s_write_req,
    input  logic [DATA_WIDTH-1:0] s_write_data,
    input  logic [ADDR_WIDTH-1:0] s_read_addr,
    input  logic                  s_read_req,
    output logic [DATA_WIDTH-1:0] s_read_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_read_data;

    // Array is never reset so it maps onto block/distributed RAM; writes commit even in reset.
    always_ff @(posedge clk) begin
        if (s_write_req) begin
            r_mem[s_write_addr] <= s_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= '0;
        end else if (s_read_req) begin
            r_read_data <= r_mem[s_read_addr];
        end
    end

    assign s_read_data = r_read_data;

endmodule

// File: tb/tb_ram.sv
// Randomised self-checking bench for ram against an array-based reference model.
module tb_ram;

    localparam int AW    = 5;
    localparam int DW    = 48;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic [AW-1:0] s_write_addr;
    logic          s_write_req;
    logic [DW-1:0] s_write_data;
    logic [AW-1:0] s_read_addr;
    logic          s_read_req;
    logic [DW-1:0] s_read_data;

    ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_write_addr(s_write_addr),
        .s_write_req (s_write_req),
        .s_write_data(s_write_data),
        .s_read_addr (s_read_addr),
        .s_read_req  (s_read_req),
        .s_read_data (s_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] model_mem [0:DEPTH-1];
    logic [DW-1:0] model_rd;
    int            n_checks;
    int            n_fail;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; the model applies the edge's rules: read old contents, then write.
    task automatic tick();
        @(posedge clk);
        if (reset)           model_rd = '0;
        else if (s_read_req) model_rd = model_mem[s_read_addr];
        if (s_write_req)     model_mem[s_write_addr] = s_write_data;
        #1;
    endtask

    task automatic idle();
        s_write_req  = 1'b0;
        s_read_req   = 1'b0;
        s_write_addr = '0;
        s_read_addr  = '0;
        s_write_data = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_rd = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        idle();

        // Reset with read requested: output stays zero throughout and just after.
        reset       = 1'b1;
        s_read_req  = 1'b1;
        s_read_addr = 5'd0;
        tick();
        chk("reset_c0", s_read_data, '0);
        tick();
        chk("reset_c1", s_read_data, '0);
        reset = 1'b0;
        idle();
        chk("reset_after", s_read_data, '0);

        // Basic write then read.
        s_write_req = 1'b1; s_write_addr = 5'd3; s_write_data = 48'hABCD;
        tick();
        idle();
        s_read_req = 1'b1; s_read_addr = 5'd3;
        tick();
        chk("basic_rd", s_read_data, 48'hABCD);

        // Read-first collision.
        idle();
        s_write_req = 1'b1; s_write_addr = 5'd5; s_write_data = 48'h1111;
        tick();
        s_write_data = 48'h2222;
        s_read_req = 1'b1; s_read_addr = 5'd5;
        tick();
        chk("collide_old", s_read_data, 48'h1111);
        s_write_req = 1'b0;
        tick();
        chk("collide_new", s_read_data, 48'h2222);

        // Hold while not reading, even as the source address is overwritten.
        idle();
        s_read_req = 1'b1; s_read_addr = 5'd3;
        tick();
        chk("hold_rd", s_read_data, 48'hABCD);
        s_read_req = 1'b0;
        s_write_req = 1'b1; s_write_addr = 5'd3; s_write_data = 48'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold_%0d", i), s_read_data, 48'hABCD);
        end

        // Full sweep: write every address, then stream reads with no bubbles.
        idle();
        s_write_req = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            s_write_addr = a[AW-1:0];
            s_write_data = DW'(a ^ 32'h5A5A);
            tick();
        end
        idle();
        s_read_req = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            s_read_addr = a[AW-1:0];
            tick();
            chk($sformatf("sweep_%0d", a), s_read_data, DW'(a ^ 32'h5A5A));
        end

        // Reset does not clear memory.
        idle();
        s_write_req = 1'b1; s_write_addr = 5'd31; s_write_data = 48'h7;
        tick();
        idle();
        reset = 1'b1;
        tick();
        chk("rstpulse_out", s_read_data, '0);
        reset = 1'b0;
        s_read_req = 1'b1; s_read_addr = 5'd31;
        tick();
        chk("rst_keep", s_read_data, 48'h7);

        // Randomised traffic with occasional resets, checked against the model.
        for (int c = 0; c < 400; c++) begin
            reset        = ($urandom_range(0, 39) == 0);
            s_write_req  = $urandom_range(0, 1) == 1;
            s_read_req   = $urandom_range(0, 2) != 0;
            s_write_addr = AW'($urandom_range(0, DEPTH - 1));
            s_read_addr  = ($urandom_range(0, 3) == 0) ? s_write_addr
                                                       : AW'($urandom_range(0, DEPTH - 1));
            s_write_data = {$urandom(), $urandom()} >> 16;
            tick();
            chk($sformatf("rand_%0d", c), s_read_data, model_rd);
        end
        reset = 1'b0;
        idle();

        // Final readback of every entry.
        s_read_req = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            s_read_addr = a[AW-1:0];
            tick();
            chk($sformatf("final_%0d", a), s_read_data, model_mem[a]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
